ysyx_22041211_ifu_fetch: RTL

//  Instruction fetch unit replacing the combinational DPI fetch in the core top. Owns the PC,

---
 rtl/ysyx_22041211_ifu_fetch.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041211_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_ifu_fetch
//
// Instruction fetch unit. Owns the fetch PC, issues at most one outstanding
// instruction read over a valid/ready request channel with a valid-only
// response channel, and buffers fetched {pc, inst, err} triples in a small
// FIFO that feeds the decoder. A redirect (branch/jump) replaces the PC,
// flushes the FIFO and squashes any response still in flight.
//
// Ports
//   clk_i             clock, all state on the rising edge
//   rst_ni            asynchronous active-low reset
//   mem_req_valid_o   read request valid
//   mem_req_ready_i   memory accepts the request
//   mem_req_addr_o    request address (word aligned)
//   mem_rsp_valid_i   read data valid, one pulse per accepted request
//   mem_rsp_data_i    instruction word
//   mem_rsp_err_i     access fault for this response
//   redirect_valid_i  replace fetch PC and flush the buffer
//   redirect_pc_i     new PC, low two bits ignored
//   out_valid_o       FIFO head valid towards the decoder
//   out_ready_i       decoder consumes the head entry
//   out_pc_o          PC of the head instruction
//   out_inst_o        head instruction word
//   out_err_o         head instruction faulted on fetch
//   pc_o              next PC to be requested
// ---------------------------------------------------------------------------
module ysyx_22041211_ifu_fetch #(
    parameter int unsigned          DATA_LEN  = 32,
    parameter int unsigned          ADDR_LEN  = 32,
    parameter logic [ADDR_LEN-1:0]  RESET_PC  = 32'h8000_0000,
    parameter int unsigned          PC_STEP   = 4,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [DATA_LEN-1:0] mem_rsp_data_i,
    input  logic                mem_rsp_err_i,
    input  logic                redirect_valid_i,
    input  logic [ADDR_LEN-1:0] redirect_pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ADDR_LEN-1:0] out_pc_o,
    output logic [DATA_LEN-1:0] out_inst_o,
    output logic                out_err_o,
    output logic [ADDR_LEN-1:0] pc_o
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [ADDR_LEN-1:0] STEP_W = ADDR_LEN'(PC_STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Pointer advance that wraps at BUF_DEPTH-1, so non-trivial depths of 1 work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + PTR_ONE;
        end
        return nxt;
    endfunction

    state_e                 state_q,  state_d;
    logic [ADDR_LEN-1:0]    pc_q,     pc_d;
    logic [ADDR_LEN-1:0]    req_pc_q, req_pc_d;
    logic                   drop_q,   drop_d;
    logic                   halted_q, halted_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;

    logic [ADDR_LEN-1:0]    buf_pc_q   [BUF_DEPTH];
    logic [DATA_LEN-1:0]    buf_inst_q [BUF_DEPTH];
    logic                   buf_err_q  [BUF_DEPTH];

    logic                   push_s;
    logic                   pop_s;
    logic                   out_valid_s;
    logic                   space_s;
    logic [CNT_W:0]         occupancy_s;
    logic [ADDR_LEN-1:0]    redirect_aligned_s;

    // An outstanding read reserves a FIFO slot so its response can always be pushed.
    assign occupancy_s        = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q == ST_WAIT)};
    assign space_s            = (occupancy_s < DEPTH_W);
    assign out_valid_s        = (count_q != CNT_ZERO);
    assign redirect_aligned_s = {redirect_pc_i[ADDR_LEN-1:2], 2'b00};

    // Next-state logic for the fetch FSM, the PC and the FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        halted_d = halted_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push_s   = 1'b0;
        pop_s    = 1'b0;

        if (redirect_valid_i) begin
            // Redirect wins over everything: flush, unhalt, and decide whether a
            // response is still owed by the memory (then it must be squashed).
            pc_d     = redirect_aligned_s;
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
            halted_d = 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        // The owed response is arriving now; discarding it settles the debt.
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        // Memory took the stale request this cycle; its reply must be eaten.
                        drop_d  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end
                end
                ST_IDLE: begin
                    drop_d  = 1'b0;
                    state_d = ST_REQ;
                end
                default: begin
                    drop_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            push_s   = (state_q == ST_WAIT) && mem_rsp_valid_i && !drop_q;
            pop_s    = out_valid_s && out_ready_i;
            count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
            rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            // A faulting fetch stops the stream until software redirects.
            halted_d = halted_q | (push_s & mem_rsp_err_i);
            case (state_q)
                ST_IDLE: begin
                    if (space_s && !halted_q) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + STEP_W;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d  = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        drop_d = 1'b0;
                        if (({1'b0, count_d} < DEPTH_W) && !halted_d) begin
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= {ADDR_LEN{1'b0}};
            drop_q   <= 1'b0;
            halted_q <= 1'b0;
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            halted_q <= halted_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_pc_q[i]   <= {ADDR_LEN{1'b0}};
                buf_inst_q[i] <= {DATA_LEN{1'b0}};
                buf_err_q[i]  <= 1'b0;
            end
        end else if (push_s) begin
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
            buf_inst_q[wr_ptr_q] <= mem_rsp_data_i;
            buf_err_q[wr_ptr_q]  <= mem_rsp_err_i;
        end
    end

    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_addr_o  = pc_q;
    assign pc_o            = pc_q;
    assign out_valid_o     = out_valid_s;
    assign out_pc_o        = buf_pc_q[rd_ptr_q];
    assign out_inst_o      = buf_inst_q[rd_ptr_q];
    assign out_err_o       = buf_err_q[rd_ptr_q];

endmodule
